// File: rtl/gen_sram_bank_ring.sv
// gen_sram_bank_ring
//   N-bank SRAM line-buffer controller. In CNN mode the write role rotates
//   around the banks, and reads are taken from any bank that is not the
//   current write bank. Once NBANK-1 banks are filled, the block enters
//   write+read automatically. In full-connect mode the banks are filled
//   first and then read back. Writes and reads that target a bank the
//   current state does not allow are refused and raise sticky error flags.
//
// Ports
//   SYS_CLK, SYS_RST          clock, asynchronous active-low reset
//   mode_i                    [2:0] CNN (has priority), [3] full-connect
//   data_sop_i / data_eop_i   frame start / frame end (FC: go to read)
//   bank_adv_i                current write bank complete, advance
//   wr_done_i / rd_done_i     CNN write phase over / read phase over
//   waddr_i, wdata_i, wvld_i  {bank, word} write request
//   raddr_i, rvld_i           {bank, word} read request
//   sram_cen_o/_wen_o         per-bank strobe / write enable
//   sram_addr_o/_din_o        per-bank address / write data (bank b at b*W)
//   sram_dout_i               per-bank read data, RD_LAT cycles after access
//   rdata_o, rdata_vld_o      returned read data and its valid flag
//   wbank_o                   current write bank
//   sram_status_o             one-hot state
//   err_o                     sticky {rd_err, wr_err}
module gen_sram_bank_ring #(
   parameter int AW     = 10,
   parameter int DW     = 128,
   parameter int NBANK  = 3,
   parameter int RD_LAT = 1,
   localparam int BW    = $clog2(NBANK)
) (
   input  logic                  SYS_CLK,
   input  logic                  SYS_RST,
   input  logic [3:0]            mode_i,
   input  logic                  data_sop_i,
   input  logic                  data_eop_i,
   input  logic                  bank_adv_i,
   input  logic                  wr_done_i,
   input  logic                  rd_done_i,
   input  logic [BW+AW-1:0]      waddr_i,
   input  logic [DW-1:0]         wdata_i,
   input  logic                  wvld_i,
   input  logic [BW+AW-1:0]      raddr_i,
   input  logic                  rvld_i,
   output logic [NBANK-1:0]      sram_cen_o,
   output logic [NBANK-1:0]      sram_wen_o,
   output logic [NBANK*AW-1:0]   sram_addr_o,
   output logic [NBANK*DW-1:0]   sram_din_o,
   input  logic [NBANK*DW-1:0]   sram_dout_i,
   output logic [DW-1:0]         rdata_o,
   output logic                  rdata_vld_o,
   output logic [BW-1:0]         wbank_o,
   output logic [3:0]            sram_status_o,
   output logic [1:0]            err_o
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_WSRAM  = 4'b0010,
      S_RSRAM  = 4'b0100,
      S_WRSRAM = 4'b1000
   } state_t;

   state_t          state, state_n;
   logic [BW-1:0]   wbank, wbank_n;
   logic [BW-1:0]   fill_cnt, fill_cnt_n;
   logic [1:0]      err_q, err_n;

   logic            cnn_mode, fc_mode;
   logic [BW-1:0]   wr_bank, rd_bank;
   logic            wr_acc, rd_acc, rd_in_range, rd_readable;

   logic [RD_LAT-1:0] rd_vld_p;
   logic [BW-1:0]     rd_bank_p [RD_LAT];

   // Next bank in the ring, wrapping NBANK-1 back to 0.
   function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
      if (b == BW'(NBANK - 1))
         return '0;
      else
         return b + 1'b1;
   endfunction

   assign cnn_mode = |mode_i[2:0];
   assign fc_mode  = mode_i[3] & ~cnn_mode;

   assign wr_bank  = waddr_i[AW +: BW];
   assign rd_bank  = raddr_i[AW +: BW];

   // Writes go only to the bank currently owning the write role.
   assign wr_acc = wvld_i && (state == S_WSRAM || state == S_WRSRAM) &&
                   (wr_bank == wbank);

   // Reads are legal in read-only, or in write+read from any bank other than
   // the write bank, so a read and a write can never collide on one bank.
   assign rd_in_range = (int'(rd_bank) < NBANK);
   assign rd_readable = (state == S_RSRAM) ||
                        (state == S_WRSRAM && rd_bank != wbank);
   assign rd_acc      = rvld_i && rd_in_range && rd_readable;

   // ---- control state register ----
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         state    <= S_IDLE;
         wbank    <= '0;
         fill_cnt <= '0;
         err_q    <= '0;
      end else begin
         state    <= state_n;
         wbank    <= wbank_n;
         fill_cnt <= fill_cnt_n;
         err_q    <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      wbank_n    = wbank;
      fill_cnt_n = fill_cnt;
      err_n      = err_q | {rvld_i & ~rd_acc, wvld_i & ~wr_acc};

      if (data_sop_i) begin
         // Frame start wins over everything, including this cycle's errors.
         state_n    = S_WSRAM;
         wbank_n    = '0;
         fill_cnt_n = '0;
         err_n      = '0;
      end else begin
         unique case (state)
            S_WSRAM: begin
               if (fc_mode) begin
                  if (data_eop_i)
                     state_n = S_RSRAM;
                  else if (bank_adv_i)
                     wbank_n = bank_inc(wbank);
               end else if (cnn_mode && bank_adv_i) begin
                  // NBANK-1 banks now hold data: start overlapping reads.
                  if (fill_cnt == BW'(NBANK - 2)) begin
                     state_n = S_WRSRAM;
                     wbank_n = BW'(NBANK - 1);
                  end else begin
                     wbank_n    = wbank + 1'b1;
                     fill_cnt_n = fill_cnt + 1'b1;
                  end
               end
            end
            S_WRSRAM: begin
               if (wr_done_i)
                  state_n = S_RSRAM;
               else if (bank_adv_i)
                  wbank_n = bank_inc(wbank);
            end
            S_RSRAM: begin
               if (rd_done_i)
                  state_n = S_IDLE;
            end
            S_IDLE: begin
               state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // ---- SRAM strobes (combinational from accepted requests) ----
   always_comb begin
      sram_cen_o  = '0;
      sram_wen_o  = '0;
      sram_addr_o = '0;
      sram_din_o  = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (wr_acc && wbank == BW'(b)) begin
            sram_cen_o[b]          = 1'b1;
            sram_wen_o[b]          = 1'b1;
            sram_addr_o[b*AW +: AW] = waddr_i[AW-1:0];
            sram_din_o[b*DW +: DW]  = wdata_i;
         end else if (rd_acc && rd_bank == BW'(b)) begin
            sram_cen_o[b]          = 1'b1;
            sram_addr_o[b*AW +: AW] = raddr_i[AW-1:0];
         end
      end
   end

   // ---- read return pipeline: RD_LAT stages matching the SRAM latency ----
   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         rd_vld_p <= '0;
      end else begin
         rd_vld_p[0] <= rd_acc;
         for (int i = 1; i < RD_LAT; i++)
            rd_vld_p[i] <= rd_vld_p[i-1];
      end
   end

   // Bank index travels with the valid bit; it is only used when valid.
   always_ff @(posedge SYS_CLK) begin
      rd_bank_p[0] <= rd_bank;
      for (int i = 1; i < RD_LAT; i++)
         rd_bank_p[i] <= rd_bank_p[i-1];
   end

   always_comb begin
      rdata_o = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (rd_vld_p[RD_LAT-1] && rd_bank_p[RD_LAT-1] == BW'(b))
            rdata_o = sram_dout_i[b*DW +: DW];
      end
   end

   assign rdata_vld_o   = rd_vld_p[RD_LAT-1];
   assign wbank_o       = wbank;
   assign sram_status_o = state;
   assign err_o         = err_q;

endmodule
